// File: rtl/tmr_scrub_pkg.sv
// +--------------------------------------------------------------------------+
// | tmr_scrub_pkg : shared state encoding and copy indices for the TMR bank  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package tmr_scrub_pkg;

  typedef logic [1:0] scrub_state_t;

  localparam scrub_state_t ST_IDLE = 2'd0;
  localparam scrub_state_t ST_READ = 2'd1;
  localparam scrub_state_t ST_FIX  = 2'd2;

  localparam logic [1:0] COPY_A = 2'd0;
  localparam logic [1:0] COPY_B = 2'd1;
  localparam logic [1:0] COPY_C = 2'd2;

  localparam int NUM_COPIES = 3;

endpackage

`default_nettype wire

// File: rtl/tmr_scrub_if.sv
// +--------------------------------------------------------------------------+
// | tmr_scrub_if : user write/read, fault-injection and status bundle        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface tmr_scrub_if #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int ERR_CNT_W = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                 wr_valid;
  logic                 wr_ready;
  logic [AW-1:0]        wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic                 rd_req;
  logic [AW-1:0]        rd_addr;
  logic                 rd_ack;
  logic [WIDTH-1:0]     rd_data;
  logic                 rd_mismatch;
  logic                 inj_valid;
  logic [1:0]           inj_copy;
  logic [AW-1:0]        inj_addr;
  logic [WIDTH-1:0]     inj_mask;
  logic [ERR_CNT_W-1:0] err_count;
  logic [AW-1:0]        scrub_addr;
  logic                 scrub_busy;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr,
           inj_valid, inj_copy, inj_addr, inj_mask,
    input  wr_ready, rd_ack, rd_data, rd_mismatch,
           err_count, scrub_addr, scrub_busy
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req, rd_addr,
           inj_valid, inj_copy, inj_addr, inj_mask,
    output wr_ready, rd_ack, rd_data, rd_mismatch,
           err_count, scrub_addr, scrub_busy
  );

endinterface

`default_nettype wire

// File: rtl/tmr_voter3.sv
// +--------------------------------------------------------------------------+
// | tmr_voter3 : bitwise 2-of-3 majority with any-disagreement flag          |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tmr_voter3 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] voted,
  output logic             mismatch
);

  assign voted    = (a & b) | (b & c) | (a & c);
  assign mismatch = |((a ^ b) | (b ^ c) | (a ^ c));

endmodule

`default_nettype wire

// File: rtl/tmr_scrub_ctrl.sv
// +--------------------------------------------------------------------------+
// | tmr_scrub_ctrl : triplicated register bank with periodic majority scrub  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tmr_scrub_ctrl
  import tmr_scrub_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int SCRUB_PERIOD = 64,
  parameter int ERR_CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  tmr_scrub_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(SCRUB_PERIOD);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(SCRUB_PERIOD - 1);

  logic [DEPTH-1:0][WIDTH-1:0] copies [NUM_COPIES];

  scrub_state_t         state;
  logic [TW-1:0]        timer;
  logic [AW-1:0]        scrub_addr_q;
  logic [AW-1:0]        fix_addr;
  logic [WIDTH-1:0]     fix_word;
  logic [ERR_CNT_W-1:0] err_q;

  logic [WIDTH-1:0]     rd_vote;
  logic                 rd_mm;
  logic [WIDTH-1:0]     scrub_vote;
  logic                 scrub_mm;

  logic                 rd_ack_q;
  logic [WIDTH-1:0]     rd_data_q;
  logic                 rd_mm_q;

  logic                 fix_we;
  logic                 wr_fire;
  logic                 write_hits_scrub;

  assign fix_we           = (state == ST_FIX);
  assign wr_fire          = bus.wr_valid && !fix_we;
  assign write_hits_scrub = bus.wr_valid && (bus.wr_addr == scrub_addr_q);

  // Update order per word: user write, then scrub fix, then fault injection.
  for (genvar k = 0; k < NUM_COPIES; k++) begin : g_copy
    localparam logic [1:0] CK = 2'(k);

    logic [DEPTH-1:0][WIDTH-1:0] store_q;
    logic [DEPTH-1:0][WIDTH-1:0] store_d;

    always_comb begin
      store_d = store_q;
      if (wr_fire) begin
        store_d[bus.wr_addr] = bus.wr_data;
      end
      if (fix_we) begin
        store_d[fix_addr] = fix_word;
      end
      if (bus.inj_valid && (bus.inj_copy == CK)) begin
        store_d[bus.inj_addr] = store_d[bus.inj_addr] ^ bus.inj_mask;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        store_q <= '0;
      end else begin
        store_q <= store_d;
      end
    end

    assign copies[k] = store_q;
  end

  tmr_voter3 #(.WIDTH(WIDTH)) u_rd_voter (
    .a        (copies[COPY_A][bus.rd_addr]),
    .b        (copies[COPY_B][bus.rd_addr]),
    .c        (copies[COPY_C][bus.rd_addr]),
    .voted    (rd_vote),
    .mismatch (rd_mm)
  );

  tmr_voter3 #(.WIDTH(WIDTH)) u_scrub_voter (
    .a        (copies[COPY_A][scrub_addr_q]),
    .b        (copies[COPY_B][scrub_addr_q]),
    .c        (copies[COPY_C][scrub_addr_q]),
    .voted    (scrub_vote),
    .mismatch (scrub_mm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      rd_mm_q   <= 1'b0;
    end else begin
      rd_ack_q <= bus.rd_req;
      if (bus.rd_req) begin
        rd_data_q <= rd_vote;
        rd_mm_q   <= rd_mm;
      end
    end
  end

  // Leaving IDLE on the edge where the timer would hit 0 keeps visits
  // exactly SCRUB_PERIOD cycles apart when no FIX is inserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      timer        <= TIMER_RELOAD;
      scrub_addr_q <= '0;
      fix_addr     <= '0;
      fix_word     <= '0;
      err_q        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (timer == TW'(1)) begin
            state <= ST_READ;
            timer <= TIMER_RELOAD;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_READ: begin
          fix_word     <= scrub_vote;
          fix_addr     <= scrub_addr_q;
          scrub_addr_q <= scrub_addr_q + 1'b1;
          // A concurrent user write makes the voted snapshot stale.
          if (write_hits_scrub) begin
            state <= ST_IDLE;
          end else if (scrub_mm) begin
            state <= ST_FIX;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FIX: begin
          if (err_q != '1) begin
            err_q <= err_q + 1'b1;
          end
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.wr_ready    = !fix_we;
  assign bus.rd_ack      = rd_ack_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_mismatch = rd_mm_q;
  assign bus.err_count   = err_q;
  assign bus.scrub_addr  = scrub_addr_q;
  assign bus.scrub_busy  = (state == ST_READ) || (state == ST_FIX);

endmodule

`default_nettype wire

// File: tb/tb_tmr_scrub_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_tmr_scrub_ctrl : vector table, corner sequences and random vs. model  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_tmr_scrub_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int P     = 8;
  localparam int ECW   = 2;
  localparam int ERR_MAX = (1 << ECW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tmr_scrub_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ERR_CNT_W(ECW)) bus ();

  tmr_scrub_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .SCRUB_PERIOD(P), .ERR_CNT_W(ECW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference model: storage, read response, and a visit schedule counted
  // in idle cycles remaining before the next scrub visit.
  logic [7:0] m_mem [3][DEPTH];
  logic       m_ack;
  logic [7:0] m_rdata;
  logic       m_mm;
  int         m_err;
  int         m_saddr;
  int         m_until;
  bit         m_fix;
  int         m_fix_addr;
  logic [7:0] m_fix_word;

  int n_cmp = 0;
  int n_fail = 0;
  int stalls = 0;
  int wraps = 0;
  int prev_saddr = 0;

  typedef struct {
    int         addr;
    logic [7:0] data;
    logic [1:0] copy;
    logic [7:0] mask;
    logic [7:0] exp_data;
    logic       exp_mm;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [7:0] vote3(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      r[i] = (ones >= 2);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < DEPTH; a++) m_mem[k][a] = 8'h00;
    m_ack = 0; m_rdata = 0; m_mm = 0; m_err = 0; m_saddr = 0;
    m_until = P - 1; m_fix = 0; m_fix_addr = 0; m_fix_word = 0;
  endtask

  task automatic model_step();
    logic [7:0] old [3][DEPTH];
    bit in_fix, in_read;
    if (rst) begin
      model_reset();
      return;
    end
    old = m_mem;
    in_fix  = m_fix;
    in_read = (m_until == 0) && !m_fix;
    m_ack = bus.rd_req;
    if (bus.rd_req) begin
      m_rdata = vote3(old[0][bus.rd_addr], old[1][bus.rd_addr], old[2][bus.rd_addr]);
      m_mm = !(old[0][bus.rd_addr] == old[1][bus.rd_addr] &&
               old[1][bus.rd_addr] == old[2][bus.rd_addr]);
    end
    if (bus.wr_valid && !in_fix)
      for (int k = 0; k < 3; k++) m_mem[k][bus.wr_addr] = bus.wr_data;
    if (in_fix) begin
      for (int k = 0; k < 3; k++) m_mem[k][m_fix_addr] = m_fix_word;
      if (m_err < ERR_MAX) m_err++;
    end
    if (bus.inj_valid && bus.inj_copy != 2'd3)
      m_mem[bus.inj_copy][bus.inj_addr] = m_mem[bus.inj_copy][bus.inj_addr] ^ bus.inj_mask;
    if (in_read) begin
      m_fix_word = vote3(old[0][m_saddr], old[1][m_saddr], old[2][m_saddr]);
      m_fix_addr = m_saddr;
      m_fix = !(old[0][m_saddr] == old[1][m_saddr] && old[1][m_saddr] == old[2][m_saddr])
              && !(bus.wr_valid && int'(bus.wr_addr) == m_saddr);
      m_saddr = (m_saddr + 1) % DEPTH;
      m_until = P - 1;
    end else if (in_fix) begin
      m_fix = 0;
    end else begin
      m_until--;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("wr_ready", bus.wr_ready, !m_fix);
    check("scrub_busy", bus.scrub_busy, m_fix || (m_until == 0));
    check("scrub_addr", bus.scrub_addr, m_saddr);
    check("err_count", bus.err_count, m_err);
    check("rd_ack", bus.rd_ack, m_ack);
    check("rd_data", bus.rd_data, m_rdata);
    check("rd_mismatch", bus.rd_mismatch, m_mm);
    if (!bus.wr_ready) stalls++;
    if (prev_saddr == DEPTH - 1 && int'(bus.scrub_addr) == 0) wraps++;
    prev_saddr = int'(bus.scrub_addr);
  endtask

  task automatic clear_inputs();
    bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.rd_req = 0; bus.rd_addr = 0;
    bus.inj_valid = 0; bus.inj_copy = 0; bus.inj_addr = 0; bus.inj_mask = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1; tick(); tick();
    rst = 0;
    stalls = 0; wraps = 0;
  endtask

  task automatic do_read(input int addr);
    bus.rd_req = 1; bus.rd_addr = 4'(addr);
    tick();
    bus.rd_req = 0;
  endtask

  task automatic inject(input int copy, input int addr, input logic [7:0] mask);
    bus.inj_valid = 1; bus.inj_copy = 2'(copy); bus.inj_addr = 4'(addr); bus.inj_mask = mask;
    tick();
    bus.inj_valid = 0;
  endtask

  task automatic wait_fix(output bit found);
    found = 0;
    for (int i = 0; i < 20 * (P + 1) && !found; i++) begin
      tick();
      if (!bus.wr_ready) found = 1;
    end
  endtask

  initial begin
    bit found;
    int s0;
    clear_inputs();
    vecs[0] = '{3,  8'hA5, 2'd1, 8'h0F, 8'hA5, 1'b1};
    vecs[1] = '{4,  8'h3C, 2'd0, 8'hFF, 8'h3C, 1'b1};
    vecs[2] = '{5,  8'h00, 2'd3, 8'hFF, 8'h00, 1'b0};
    vecs[3] = '{6,  8'h5A, 2'd2, 8'h00, 8'h5A, 1'b0};
    vecs[4] = '{9,  8'h81, 2'd2, 8'h80, 8'h81, 1'b1};
    vecs[5] = '{15, 8'hFF, 2'd0, 8'h01, 8'hFF, 1'b1};

    // Reset values and a first read
    do_reset();
    check("rst_wr_ready", bus.wr_ready, 1);
    check("rst_busy", bus.scrub_busy, 0);
    check("rst_err", bus.err_count, 0);
    check("rst_saddr", bus.scrub_addr, 0);
    check("rst_rd_ack", bus.rd_ack, 0);
    do_read(5);
    check("rd5_ack", bus.rd_ack, 1);
    check("rd5_data", bus.rd_data, 8'h00);
    check("rd5_mm", bus.rd_mismatch, 0);

    // Vector table: write+inject in one cycle, then read back the vote
    for (int v = 0; v < 6; v++) begin
      for (int g = 0; g < 4 && !bus.wr_ready; g++) tick();
      bus.wr_valid = 1; bus.wr_addr = 4'(vecs[v].addr); bus.wr_data = vecs[v].data;
      bus.inj_valid = 1; bus.inj_copy = vecs[v].copy;
      bus.inj_addr = 4'(vecs[v].addr); bus.inj_mask = vecs[v].mask;
      tick();
      clear_inputs();
      do_read(vecs[v].addr);
      check("vec_data", bus.rd_data, vecs[v].exp_data);
      check("vec_mm", bus.rd_mismatch, vecs[v].exp_mm);
    end

    // Four single-copy faults scrubbed: counter saturates, one stall each
    for (int i = 0; i < 16 * (P + 1) + 8; i++) tick();
    check("sat_err", bus.err_count, 3);
    check("sat_stalls", stalls, 4);
    check("saddr_wrapped", wraps >= 1, 1);
    do_read(3);
    check("fixed3_data", bus.rd_data, 8'hA5);
    check("fixed3_mm", bus.rd_mismatch, 0);

    // Single fix: exactly one stall cycle, count becomes 1
    do_reset();
    bus.wr_valid = 1; bus.wr_addr = 4'd3; bus.wr_data = 8'hA5;
    tick();
    clear_inputs();
    inject(1, 3, 8'h0F);
    wait_fix(found);
    check("fix_seen", found, 1);
    check("fix_busy", bus.scrub_busy, 1);
    check("fix_err_before", bus.err_count, 0);
    tick();
    check("fix_one_stall", bus.wr_ready, 1);
    check("fix_err_after", bus.err_count, 1);
    do_read(3);
    check("fix_rd_data", bus.rd_data, 8'hA5);
    check("fix_rd_mm", bus.rd_mismatch, 0);

    // Two-copy fault: majority wins and is written back
    do_reset();
    inject(0, 2, 8'h01);
    inject(1, 2, 8'h01);
    wait_fix(found);
    check("maj_fix_seen", found, 1);
    tick();
    do_read(2);
    check("maj_data", bus.rd_data, 8'h01);
    check("maj_mm", bus.rd_mismatch, 0);
    check("maj_err", bus.err_count, 1);

    // Write to the scrubbed word during its READ cycle discards the visit
    do_reset();
    found = 0;
    for (int i = 0; i < 20 * (P + 1) && !found; i++) begin
      tick();
      if (m_until == 1 && !m_fix && m_saddr == 7) found = 1;
    end
    check("pre_read7", found, 1);
    inject(0, 7, 8'hFF);
    s0 = stalls;
    bus.wr_valid = 1; bus.wr_addr = 4'd7; bus.wr_data = 8'h3C;
    tick();
    clear_inputs();
    for (int i = 0; i < P + 2; i++) tick();
    check("discard_stalls", stalls - s0, 0);
    check("discard_err", bus.err_count, 0);
    do_read(7);
    check("discard_data", bus.rd_data, 8'h3C);
    check("discard_mm", bus.rd_mismatch, 0);

    // Reset during FIX aborts the correction
    do_reset();
    inject(2, 0, 8'h55);
    wait_fix(found);
    check("abort_fix_seen", found, 1);
    rst = 1;
    tick();
    rst = 0;
    check("abort_err", bus.err_count, 0);
    check("abort_ready", bus.wr_ready, 1);
    tick();
    check("abort_err2", bus.err_count, 0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.wr_valid = ($urandom_range(0, 9) < 3);
      bus.wr_addr = 4'($urandom_range(0, DEPTH - 1));
      bus.wr_data = 8'($urandom);
      bus.rd_req = ($urandom_range(0, 1) == 1);
      bus.rd_addr = 4'($urandom_range(0, DEPTH - 1));
      bus.inj_valid = ($urandom_range(0, 9) == 0);
      bus.inj_copy = 2'($urandom_range(0, 3));
      bus.inj_addr = 4'($urandom_range(0, DEPTH - 1));
      bus.inj_mask = 8'($urandom);
      tick();
    end
    rst = 0;
    clear_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
